// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// State encodings are fixed so trace and debug tools can decode them.
package fetch_ctrl_pkg;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned MEM_SIZE = 15;
  localparam int unsigned PC_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [WIDTH-1:0] inst;
    logic [PC_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small in-order FIFO of fetched {inst, pc}; entry 0 is always the head,
// so head outputs come straight from a register.
module fetch_buf
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                push,
  input  fetch_entry_t                        din,
  input  logic                                pop,
  input  logic                                flush,
  output logic [$clog2(BUF_DEPTH+1)-1:0]      count,
  output logic                                valid,
  output fetch_entry_t                        head
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_entry_t     ent0_q, ent0_d;
  fetch_entry_t     ent1_q, ent1_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q;
  logic             do_pop;
  logic             do_push;

  // Next-state: flush dominates; simultaneous push/pop keeps the count.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    do_pop  = pop && (count_q != CNT_W'(0));
    do_push = push && ((count_q < CNT_W'(BUF_DEPTH)) || do_pop);
    if (flush) begin
      count_d = CNT_W'(0);
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (count_q == CNT_W'(0)) ent0_d = din;
          else                      ent1_d = din;
          count_d = count_q + CNT_W'(1);
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - CNT_W'(1);
        end
        2'b11: begin
          if (count_q == CNT_W'(1)) begin
            ent0_d = din;
          end else begin
            ent0_d = ent1_q;
            ent1_d = din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
      valid_q <= (count_d != CNT_W'(0));
    end
  end

  assign count = count_q;
  assign valid = valid_q;
  assign head  = ent0_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: drives pc to instr_mem, buffers returned
// instructions, hands them to decode and applies execute redirects.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = MEM_SIZE + 1,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [PC_W-1:0]  pc,
  input  logic [WIDTH-1:0] inst_in,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_inst,
  output logic [PC_W-1:0]  out_pc,
  output logic             busy,
  output logic             halted
);

  localparam int unsigned CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(MEM_DEPTH - 1);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             busy_q, halted_q;
  logic             push, pop, flush, fire;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;

  // A fetch fires only if the buffer has room after this cycle's pop.
  assign pop  = out_valid & out_ready;
  assign fire = (count < CNT_W'(BUF_DEPTH)) || out_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          flush   = 1'b1;
        end
      end
      ST_FETCH, ST_DRAIN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (redirect_target < PC_W'(MEM_DEPTH)) begin
            state_d = ST_FETCH;
            pc_d    = redirect_target;
          end else begin
            state_d = ST_HALT;
          end
        end else if (state_q == ST_FETCH) begin
          if (fire) begin
            push = 1'b1;
            if (pc_q == LAST_PC) state_d = ST_DRAIN;
            else                 pc_d    = pc_q + PC_W'(1);
          end
        end else if (pop && (count == CNT_W'(1))) begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      busy_q   <= (state_d == ST_FETCH) || (state_d == ST_DRAIN);
      halted_q <= (state_d == ST_HALT);
    end
  end

  fetch_buf #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ('{inst: inst_in, pc: pc_q}),
    .pop   (pop),
    .flush (flush),
    .count (count),
    .valid (out_valid),
    .head  (head)
  );

  assign pc       = pc_q;
  assign out_inst = head.inst;
  assign out_pc   = head.pc;
  assign busy     = busy_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a combinational instruction memory model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] pc;
  logic [31:0] inst_in;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        busy;
  logic        halted;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  always #5 clk = ~clk;

  // Memory contents: a recognisable word per address.
  assign inst_in = 32'hC0DE_0000 + pc;

  fetch_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .pc              (pc),
    .inst_in         (inst_in),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .busy            (busy),
    .halted          (halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Check consecutive heads first..last, popping all but the last.
  task automatic stream(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      chk("valid", 32'(out_valid), 32'd1);
      chk("out_pc", out_pc, 32'(i));
      chk("out_inst", out_inst, 32'hC0DE_0000 + 32'(i));
      if (i != last) tick();
    end
  endtask

  // Deliver first..15 then expect HALT one cycle after PC 15 is popped.
  task automatic drain_check(input int first);
    stream(first, 15);
    tick();
    chk("halted", 32'(halted), 32'd1);
    chk("busy_h", 32'(busy), 32'd0);
    chk("valid_h", 32'(out_valid), 32'd0);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    tick();
    redirect_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; out_ready = 1'b0;
    #23 rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_pc", pc, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);

    // Full stream with out_ready held high
    out_ready = 1'b1;
    pulse_start();
    chk("s_busy", 32'(busy), 32'd1);
    chk("s_pc", pc, 32'd0);
    chk("s_valid0", 32'(out_valid), 32'd0);
    tick();
    stream(0, 14);
    chk("pc_last", pc, 32'd15);
    tick();
    chk("drain_busy", 32'(busy), 32'd1);
    drain_check(15);

    // Stall: decode not ready for 5 cycles after first valid
    out_ready = 1'b0;
    pulse_start();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_out_pc", out_pc, 32'd0);
      if (k > 0) chk("stall_pc", pc, 32'd2);
      if (k != 4) tick();
    end
    out_ready = 1'b1;
    drain_check(0);

    // Redirect to 3 while head is PC 5
    pulse_start();
    tick();
    stream(0, 5);
    redirect(32'd3);
    chk("rd_valid", 32'(out_valid), 32'd0);
    chk("rd_pc", pc, 32'd3);
    tick();
    drain_check(3);

    // Out-of-range redirect halts with pc unchanged
    pulse_start();
    tick();
    stream(0, 1);
    chk("oor_pc_pre", pc, 32'd2);
    redirect(32'hFFFF_FFFE);
    chk("oor_halted", 32'(halted), 32'd1);
    chk("oor_valid", 32'(out_valid), 32'd0);
    chk("oor_pc", pc, 32'd2);
    redirect(32'd4);
    chk("halt_ign", 32'(halted), 32'd1);
    chk("halt_ign_pc", pc, 32'd2);

    // Redirect during DRAIN back into FETCH
    pulse_start();
    tick();
    stream(0, 15);
    chk("dr_busy", 32'(busy), 32'd1);
    redirect(32'd4);
    chk("dr_rd_busy", 32'(busy), 32'd1);
    chk("dr_rd_valid", 32'(out_valid), 32'd0);
    chk("dr_rd_pc", pc, 32'd4);
    tick();
    drain_check(4);

    // start together with redirect in FETCH: redirect wins
    pulse_start();
    start = 1'b1;
    redirect(32'd7);
    start = 1'b0;
    chk("sr_pc", pc, 32'd7);
    tick();
    drain_check(7);

    // Asynchronous reset mid-FETCH with two entries buffered
    out_ready = 1'b0;
    pulse_start();
    tick();
    tick();
    chk("pre_rst_pc", pc, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_out_pc", out_pc, 32'd0);
    chk("arst_inst", out_inst, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    pulse_start();
    chk("rs_pc", pc, 32'd0);
    tick();
    drain_check(0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch sequencer between `instr_mem` and the decode stage. It drives the program counter into the instruction memory's combinational read port and captures each returned instruction with its PC into a 2-entry buffer. It presents buffered instructions to decode over a valid/ready handshake. It applies branch redirects from execute by flushing and reloading the PC, and halts when the PC leaves the populated memory range.

## Interface
Parameters:
- `MEM_DEPTH`, default `MEM_SIZE+1` (16): number of addressable instruction words; valid PCs are 0..MEM_DEPTH-1.
- `BUF_DEPTH`, default 2: buffer entries; fixed at 2.

Ports:
- `clk`  in  1  system clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse; begins fetch at PC 0 from IDLE or HALT. Ignored in other states.
- `pc`  out  32  address to `instr_mem`.
- `inst_in`  in  `WIDTH`  instruction word from `instr_mem`, combinational from `pc`.
- `redirect_valid`  in  1  branch taken in execute.
- `redirect_target`  in  32  absolute target PC.
- `out_valid`  out  1  buffer head valid.
- `out_ready`  in  1  decode accepts head.
- `out_inst`  out  `WIDTH`  head instruction.
- `out_pc`  out  32  PC of head instruction.
- `busy`  out  1  state is FETCH or DRAIN.
- `halted`  out  1  state is HALT.

## Operation
- States:
  - IDLE: after reset.
  - FETCH: issuing PCs.
  - DRAIN: no more PCs to issue, buffer not empty.
  - HALT: stopped.
- IDLE/HALT + `start` → FETCH; `pc`←0; buffer cleared.
- FETCH, each cycle: a fetch fires when the buffer has room after this cycle's pop (count<2, or count==2 with a handshake). On fire, push {`inst_in`, `pc`} and `pc`←`pc`+1.
- FETCH, fire with `pc`==MEM_DEPTH-1 → DRAIN; `pc` holds at MEM_DEPTH-1.
- DRAIN → HALT on the cycle the last entry is popped.
- Handshake: an entry is consumed when `out_valid & out_ready`. `out_inst` and `out_pc` stay stable while `out_valid & !out_ready`.
- Redirect, in FETCH or DRAIN:
  - A handshake in the same cycle still completes.
  - Then all entries are flushed, and no push happens that cycle.
  - If `redirect_target` < MEM_DEPTH: `pc`←target, state→FETCH.
  - Otherwise: state→HALT, `pc` unchanged.
- Redirect in IDLE/HALT is ignored.
- `start` and `redirect_valid` together in FETCH/DRAIN: redirect wins and `start` is ignored.
- PC arithmetic is unsigned 32-bit. Targets ≥ MEM_DEPTH, including wrapped negative offsets, are out of range.
- Reset mid-operation: all state returns to reset values immediately; buffer contents are discarded.

## Timing
- Reset values:
  - `pc`=0, `out_valid`=0, `out_inst`=0, `out_pc`=0.
  - `busy`=0, `halted`=0, state IDLE.
- `start` at cycle T: FETCH at T+1 with `pc`=0; first `out_valid` at T+2 with `out_pc`=0.
- Sustained throughput is 1 instruction/cycle when `out_ready` is held high.
- Redirect at cycle T: `out_valid`=0 at T+1, `pc`=target at T+1, first redirected instruction valid at T+2.
- `out_*` come straight from buffer registers, with no combinational path from `inst_in`.
- `out_ready` reaches only the fetch-fire enable, not `out_valid`.

## Structure
- `WIDTH`, `MEM_SIZE` and the opcode defines come from `defines.vh`.
- Add the state encodings (IDLE=0, FETCH=1, DRAIN=2, HALT=3) to `defines.vh` so trace and debug tools share them.
- Sub-module `fetch_buf`: 2-entry FIFO of {`WIDTH` inst, 32-bit pc} with push, pop, flush, count, and registered head outputs.
- `fetch_ctrl` holds the FSM, the PC register, and the fire/redirect logic.

## Test plan
- Reset → `pc`=0, `out_valid`=0, `busy`=0, `halted`=0; `start` with `out_ready`=1 → `out_pc` 0,1,2,…,15 on consecutive cycles, then `halted`=1 one cycle after PC 15 is popped.
- Stall: `out_ready`=0 for 5 cycles after first valid → `out_pc` holds 0, `pc` stops at 2, no entries are lost; releasing `out_ready` → 0,1,2,… in order.
- Redirect to 3 while the head is PC 5 and `out_ready`=1 → PC 5 is consumed, next valid `out_pc` is 3 two cycles later, and the buffered PC 6 never appears.
- Redirect to 0xFFFFFFFE → HALT next cycle, `out_valid`=0, `pc` unchanged.
- Redirect during DRAIN to 4 → state returns to FETCH and sequence 4..15 is delivered.
- `rst_n` low mid-FETCH with 2 entries buffered → outputs return to reset values asynchronously; `start` afterwards restarts from PC 0.
